// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer
//   Arbitrates the single command port of the register file between decode
//   (two-operand fetch) and writeback (one register write). It issues the
//   two operand reads back to back, collects the data, and holds the pair on
//   a valid/ready response interface. Held operands stay coherent with any
//   writebacks accepted while the response is pending.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       operand fetch handshake, req_rs / req_rt indices
//   rsp_valid/rsp_ready       operand response handshake, rsp_a / rsp_b data
//   wb_valid/wb_ready         writeback handshake, wb_addr / wb_data
//   rf_ctrl                   00 idle, 10 read, 11 write
//   rf_in_1                   write data (0 unless writing)
//   rf_in_2                   zero-extended register index (0 when idle)
//   rf_out_1                  read data, valid the cycle after a read command
module regfile_port_sequencer #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        rf_ctrl,
    output logic [DATA_W-1:0] rf_in_1,
    output logic [DATA_W-1:0] rf_in_2,
    input  logic [DATA_W-1:0] rf_out_1
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RD_B  = 2'd1;
    localparam logic [1:0] S_CAP_B = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b10;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] rs_q, rs_d;
    logic [ADDR_W-1:0] rt_q, rt_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d;
    logic [DATA_W-1:0] rsp_b_q, rsp_b_d;

    function automatic logic [DATA_W-1:0] zext(input logic [ADDR_W-1:0] a);
        return {{(DATA_W-ADDR_W){1'b0}}, a};
    endfunction

    always_comb begin
        state_d   = state_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rsp_a_d   = rsp_a_q;
        rsp_b_d   = rsp_b_q;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rsp_valid = 1'b0;
        rf_ctrl   = CMD_IDLE;
        rf_in_1   = '0;
        rf_in_2   = '0;

        case (state_q)
            S_IDLE: begin
                wb_ready  = 1'b1;
                req_ready = !wb_valid;   // writeback wins the port
                if (wb_valid) begin
                    rf_ctrl = CMD_WRITE;
                    rf_in_1 = wb_data;
                    rf_in_2 = zext(wb_addr);
                end else if (req_valid) begin
                    rs_d    = req_rs;
                    rt_d    = req_rt;
                    rf_ctrl = CMD_READ;
                    rf_in_2 = zext(req_rs);
                    state_d = S_RD_B;
                end
            end
            S_RD_B: begin
                rsp_a_d = rf_out_1;
                rf_ctrl = CMD_READ;
                rf_in_2 = zext(rt_q);
                state_d = S_CAP_B;
            end
            S_CAP_B: begin
                rsp_b_d = rf_out_1;
                state_d = S_OUT;
            end
            default: begin  // S_OUT
                wb_ready = 1'b1;
                if (wb_valid) begin
                    // Write is ordered ahead of the pending response, so the
                    // held operands are patched and the response is withheld
                    // for this cycle.
                    rf_ctrl = CMD_WRITE;
                    rf_in_1 = wb_data;
                    rf_in_2 = zext(wb_addr);
                    if (wb_addr == rs_q) rsp_a_d = wb_data;
                    if (wb_addr == rt_q) rsp_b_d = wb_data;
                end else begin
                    rsp_valid = 1'b1;
                    if (rsp_ready) state_d = S_IDLE;
                end
            end
        endcase

        // A reset cycle abandons any sequence and must not touch the file.
        if (rst) begin
            req_ready = 1'b0;
            wb_ready  = 1'b0;
            rsp_valid = 1'b0;
            rf_ctrl   = CMD_IDLE;
            rf_in_1   = '0;
            rf_in_2   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rs_q    <= '0;
            rt_q    <= '0;
            rsp_a_q <= '0;
            rsp_b_q <= '0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rsp_a_q <= rsp_a_d;
            rsp_b_q <= rsp_b_d;
        end
    end

    assign rsp_a = rsp_a_q;
    assign rsp_b = rsp_b_q;

endmodule
